// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg: shared default geometry for the pipelined adder
package pipelined_adder_pkg;
    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_STAGES = 4;
endpackage

// File: rtl/pipelined_adder_chunk.sv
// adder_chunk: CW-bit combinational add with carry-in, carry-out and carry-into-MSB tap
module adder_chunk #(
    parameter int CW = 4
) (
    input  logic [CW-1:0] x,
    input  logic [CW-1:0] y,
    input  logic          ci,
    output logic [CW-1:0] s,
    output logic          co,
    output logic          cm
);
    assign {co, s} = {1'b0, x} + {1'b0, y} + {{CW{1'b0}}, ci};
    // carry into the top bit is recovered from the top sum bit and its operands
    assign cm = x[CW-1] ^ y[CW-1] ^ s[CW-1];
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: carry-chain adder/subtractor split into STAGES chunks with valid/ready flow control
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = WIDTH / STAGES;

    logic             en;
    logic             v_q  [STAGES];
    logic             c_q  [STAGES];
    logic             o_q  [STAGES];
    logic [WIDTH-1:0] a_q  [STAGES];
    logic [WIDTH-1:0] b_q  [STAGES];
    logic [WIDTH-1:0] s_q  [STAGES];
    logic             v_in [STAGES];
    logic             c_in [STAGES];
    logic [WIDTH-1:0] a_in [STAGES];
    logic [WIDTH-1:0] b_in [STAGES];
    logic [WIDTH-1:0] s_in [STAGES];
    logic [WIDTH-1:0] s_nx [STAGES];
    logic [CW-1:0]    cs   [STAGES];
    logic             co   [STAGES];
    logic             cm   [STAGES];

    // the whole pipeline moves as one; it only freezes when a result is waiting
    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = o_q[STAGES-1];

    // stage 0 takes the raw operands (b inverted for subtract), later stages their predecessor's registers
    always_comb begin
        v_in[0] = in_valid;
        a_in[0] = a;
        b_in[0] = sub ? ~b : b;
        c_in[0] = sub | cin;
        s_in[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            v_in[k] = v_q[k-1];
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            c_in[k] = c_q[k-1];
            s_in[k] = s_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_chunk
        adder_chunk #(.CW(CW)) u_chunk (
            .x  (a_in[k][k*CW +: CW]),
            .y  (b_in[k][k*CW +: CW]),
            .ci (c_in[k]),
            .s  (cs[k]),
            .co (co[k]),
            .cm (cm[k])
        );
    end

    // each stage drops its chunk result into the partial sum it carries forward
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            s_nx[k] = s_in[k];
            s_nx[k][k*CW +: CW] = cs[k];
        end
    end

    // stage registers: cleared asynchronously, all hold together when the output stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                o_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_in[k];
                c_q[k] <= co[k];
                o_q[k] <= co[k] ^ cm[k];
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                s_q[k] <= s_nx[k];
            end
        end
    end
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: scoreboard bench for the 16-bit, 4-stage pipelined adder
module tb_pipelined_adder;
    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    res_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rdy_mode = 0;
    int   stall_lo = 0;
    int   stall_hi = 0;

    pipelined_adder #(.WIDTH(W), .STAGES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic res_t model(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc, input logic xs);
        res_t         r;
        logic [W-1:0] bb;
        logic [W:0]   full;
        bb   = xs ? ~xb : xb;
        full = {1'b0, xa} + {1'b0, bb} + {{W{1'b0}}, (xs ? 1'b1 : xc)};
        r.s  = full[W-1:0];
        r.c  = full[W];
        r.o  = (xa[W-1] == bb[W-1]) && (r.s[W-1] != xa[W-1]);
        return r;
    endfunction

    function automatic logic next_rdy();
        return rdy_mode == 0 ? 1'b1 :
               rdy_mode == 1 ? ($urandom_range(3) != 0) :
               !(cyc >= stall_lo && cyc <= stall_hi);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc, input logic xs, input res_t e);
        int n = 0;
        @(negedge clk);
        a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
        out_ready = next_rdy();
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            out_ready = next_rdy();
            #1;
            n++;
        end
        if (in_ready) q.push_back(e);
        else check("send_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            out_ready = next_rdy();
        end
    endtask

    task automatic latency_probe(input logic [W-1:0] xa, input logic [W-1:0] xb, input res_t e);
        int n = 0;
        send(xa, xb, 1'b0, 1'b0, e);
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            n++;
        end while (!out_valid && n < 10);
        check("latency", 32'(n), 32'd4);
    endtask

    // monitor: checks handshake rule, output stability under stall, and scoreboard order
    initial begin
        res_t held;
        logic hold = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) hold = 1'b0;
            else begin
                check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
                if (hold) check("stall_stable", 32'({out_valid, sum, cout, ovf}), 32'({1'b1, held}));
                hold = out_valid && !out_ready;
                held = {sum, cout, ovf};
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result actual=%h required=none at %0t", {sum, cout, ovf}, $time);
                    end else check("result", 32'({sum, cout, ovf}), 32'(q.pop_front()));
                end
            end
        end
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc, rs;
        int           n;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        latency_probe(16'h00FF, 16'h0001, '{16'h0100, 1'b0, 1'b0});
        send(16'hFFFF, 16'h0001, 1'b1, 1'b0, '{16'h0001, 1'b1, 1'b0});
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1});
        send(16'h0005, 16'h0007, 1'b0, 1'b1, '{16'hFFFE, 1'b0, 1'b0});
        send(16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1});
        send(16'h0007, 16'h0005, 1'b0, 1'b1, '{16'h0002, 1'b1, 1'b0});
        send(16'h0000, 16'h0000, 1'b0, 1'b1, '{16'h0000, 1'b1, 1'b0});
        send(16'h8000, 16'h8000, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1});
        send(16'h1234, 16'h4321, 1'b1, 1'b0, '{16'h5556, 1'b0, 1'b0});
        send(16'h0010, 16'h0001, 1'b1, 1'b1, '{16'h000F, 1'b1, 1'b0});
        idle(8);
        send(16'h0001, 16'h0002, 1'b0, 1'b0, '{16'h0003, 1'b0, 1'b0});
        send(16'h0003, 16'h0004, 1'b0, 1'b0, '{16'h0007, 1'b0, 1'b0});
        send(16'h0005, 16'h0006, 1'b0, 1'b0, '{16'h000B, 1'b0, 1'b0});
        @(negedge clk);
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sum", 32'(sum), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        idle(8);
        latency_probe(16'h0F0F, 16'h00F1, '{16'h1000, 1'b0, 1'b0});
        idle(4);
        @(negedge clk);
        stall_lo = cyc + 6;
        stall_hi = cyc + 10;
        rdy_mode = 2;
        for (int i = 0; i < 8; i++) begin
            ra = 16'(i * 16'h1111);
            rb = 16'(16'h0100 + i);
            send(ra, rb, 1'b0, 1'b0, model(ra, rb, 1'b0, 1'b0));
        end
        idle(14);
        rdy_mode = 1;
        for (int i = 0; i < 10000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            send(ra, rb, rc, rs, model(ra, rb, rc, rs));
            if ($urandom_range(7) == 0) idle(1);
        end
        rdy_mode = 0;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            idle(1);
            n++;
        end
        idle(2);
        check("drain_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
